// File: rtl/div_result_fifo.sv
// div_result_fifo: first-word-fall-through buffer for divider results,
// with a saturating count of accepted divide-by-zero results.
module div_result_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_quotient,
    input  logic [DATA_W-1:0]        in_remainder,
    input  logic                     in_div0,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_quotient,
    output logic [DATA_W-1:0]        out_remainder,
    output logic                     out_div0,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    input  logic                     clr_stats,
    output logic [CNT_W-1:0]         div0_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 2 * DATA_W + 1;
    localparam logic [AW:0]      DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      C1      = 1;
    localparam logic [AW-1:0]    P1      = 1;
    localparam logic [CNT_W-1:0] S1      = 1;
    localparam logic [CNT_W-1:0] SMAX    = '1;

    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;

    // full/empty derive from the registered count so they move with the pointers
    assign full      = count == DEPTH_C;
    assign empty     = count == '0;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign head      = empty ? '0 : mem[rd_ptr];
    assign {out_quotient, out_remainder, out_div0} = head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {in_quotient, in_remainder, in_div0};
                wr_ptr      <= wr_ptr + P1;
            end
            if (pop) rd_ptr <= rd_ptr + P1;
            if (push != pop) count <= push ? count + C1 : count - C1;
        end
    end

    // clear takes priority over a coincident increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div0_count <= '0;
        else if (clr_stats) div0_count <= '0;
        else if (push && in_div0 && div0_count != SMAX) div0_count <= div0_count + S1;
    end
endmodule

// File: tb/tb_div_result_fifo.sv
// tb_div_result_fifo: directed and random traffic checked against a queue model;
// a second instance with CNT_W=2 covers counter saturation.
module tb_div_result_fifo;
    logic       clk = 0, rst_n = 0;
    logic       in_valid = 0, in_div0 = 0, out_ready = 0, clr_stats = 0;
    logic [3:0] in_quotient = 0, in_remainder = 0;
    logic       in_ready, out_valid, out_div0, full, empty;
    logic [3:0] out_quotient, out_remainder;
    logic [2:0] count;
    logic [7:0] div0_count;
    logic       in_ready2, out_valid2, out_div02, full2, empty2;
    logic [3:0] out_quotient2, out_remainder2;
    logic [2:0] count2;
    logic [1:0] div0_count2;

    logic [8:0] mq[$];
    int         m_cnt8, m_cnt2;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    div_result_fifo #(.DATA_W(4), .DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_quotient(in_quotient), .in_remainder(in_remainder), .in_div0(in_div0),
        .out_valid(out_valid), .out_ready(out_ready), .out_quotient(out_quotient),
        .out_remainder(out_remainder), .out_div0(out_div0), .count(count),
        .full(full), .empty(empty), .clr_stats(clr_stats), .div0_count(div0_count)
    );

    div_result_fifo #(.DATA_W(4), .DEPTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .in_quotient(in_quotient), .in_remainder(in_remainder), .in_div0(in_div0),
        .out_valid(out_valid2), .out_ready(out_ready), .out_quotient(out_quotient2),
        .out_remainder(out_remainder2), .out_div0(out_div02), .count(count2),
        .full(full2), .empty(empty2), .clr_stats(clr_stats), .div0_count(div0_count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        logic [8:0] h;
        int n;
        n = mq.size();
        h = n > 0 ? mq[0] : 9'd0;
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        chk("in_ready", 32'(in_ready), 32'(n < 4));
        chk("full", 32'(full), 32'(n == 4));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("count", 32'(count), 32'(n));
        chk("out_quotient", 32'(out_quotient), 32'(h[8:5]));
        chk("out_remainder", 32'(out_remainder), 32'(h[4:1]));
        chk("out_div0", 32'(out_div0), 32'(h[0]));
        chk("div0_count", 32'(div0_count), 32'(m_cnt8));
        chk("div0_count_w2", 32'(div0_count2), 32'(m_cnt2));
        chk("count_w2", 32'(count2), 32'(n));
    endtask

    // Drive one cycle from a negedge, update the model at the posedge, check at the next negedge.
    task automatic step(input logic iv, input logic [3:0] q, input logic [3:0] r,
                        input logic d0, input logic ordy, input logic clr);
        logic do_push, do_pop;
        in_valid = iv; in_quotient = q; in_remainder = r; in_div0 = d0;
        out_ready = ordy; clr_stats = clr;
        do_push = iv && mq.size() < 4;
        do_pop  = ordy && mq.size() > 0;
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back({q, r, d0});
        if (clr) begin
            m_cnt8 = 0; m_cnt2 = 0;
        end else if (do_push && d0) begin
            m_cnt8 = m_cnt8 < 255 ? m_cnt8 + 1 : 255;
            m_cnt2 = m_cnt2 < 3 ? m_cnt2 + 1 : 3;
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic model_reset();
        mq.delete();
        m_cnt8 = 0;
        m_cnt2 = 0;
    endtask

    initial begin
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst_n = 1;
        // single push held with no consumer
        step(1, 4'd3, 4'd1, 0, 0, 0);
        repeat (5) step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0);
        // fill, refused fifth push, drain in order
        for (int i = 0; i < 4; i++) step(1, 4'(i + 5), 4'(9 - i), 1'(i & 1), 0, 0);
        step(1, 4'hF, 4'hF, 1, 0, 0);
        step(1, 4'hE, 4'hE, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);
        // continuous streaming across pointer wrap
        for (int i = 0; i < 10; i++) step(1, 4'(i), 4'(15 - i), 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // div0 counting, clear racing a div0 push, then saturation of the narrow counter
        step(1, 0, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0);
        step(1, 4'd2, 4'd1, 0, 1, 0);
        step(1, 0, 0, 1, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // asynchronous reset with three entries held
        for (int i = 0; i < 3; i++) step(1, 4'(i + 1), 4'(i + 2), 1, 0, 0);
        in_valid = 0; out_ready = 0;
        #2 rst_n = 0;
        #1 model_reset();
        check_all();
        @(negedge clk) rst_n = 1;
        // random traffic
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 40) == 0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
